// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Step counter must hold 0..WIDTH.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for shift_add_multiplier.
interface shift_add_multiplier_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic                 start_valid;
  logic                 start_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   product;
  logic                 result_valid;
  logic                 result_ready;
  logic                 busy;

  modport master (
    output start_valid, a, b, result_ready,
    input  start_ready, product, result_valid, busy
  );

  modport slave (
    input  start_valid, a, b, result_ready,
    output start_ready, product, result_valid, busy
  );

endinterface

// File: rtl/full_adder_structural.sv
// One-bit full adder cell built from gate-level expressions.
module full_adder_structural (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  logic ab_xor;
  logic ab_and;
  logic c_and;

  assign ab_xor    = a ^ b;
  assign ab_and    = a & b;
  assign c_and     = ab_xor & carry_in;
  assign sum       = ab_xor ^ carry_in;
  assign carry_out = ab_and | c_and;

endmodule

// File: rtl/partial_product_adder.sv
// 2*WIDTH-bit ripple adder for the accumulate path; carry-in is zero and the
// final carry is never formed since the product cannot overflow.
module partial_product_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  output logic [2*WIDTH-1:0] sum
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < PW - 1; i++) begin : g_fa
    full_adder_structural u_fa (
      .a         (a[i]),
      .b         (b[i]),
      .carry_in  (carry[i]),
      .sum       (sum[i]),
      .carry_out (carry[i+1])
    );
  end

  // MSB needs only the sum; its carry would be discarded.
  assign sum[PW-1] = a[PW-1] ^ b[PW-1] ^ carry[PW-1];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one shift-and-add step per clock.
// Optional early termination on exhausted multiplier: SHIFT_ADD_MUL_EARLY_TERM_EN.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = count_width(WIDTH);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("shift_add_multiplier: WIDTH must be in 2..16");
  end

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   product_q;
  logic            start_ready_q;
  logic            busy_q;
  logic            result_valid_q;

  logic            load;
  logic            step;
  logic            finish;
  logic            last_step;
  logic            start_ready_d;
  logic            busy_d;
  logic            result_valid_d;

  logic [PW-1:0]    sum;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    mcand_step;
  logic [WIDTH-1:0] mplier_step;
  logic [CW-1:0]    count_step;

  partial_product_adder #(.WIDTH(WIDTH)) u_ppa (
    .a   (acc_q),
    .b   (mcand_q),
    .sum (sum)
  );

  assign acc_step    = mplier_q[0] ? sum : acc_q;
  assign mcand_step  = mcand_q << 1;
  assign mplier_step = mplier_q >> 1;
  assign count_step  = CW'(count_q + CW'(1));

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  assign last_step = (count_q == CW'(WIDTH - 1)) || (mplier_step == '0);
`else
  assign last_step = (count_q == CW'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_valid && start_ready_q) begin
          state_d = BUSY;
          load    = 1'b1;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last_step) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    start_ready_d  = (state_d == IDLE);
    busy_d         = (state_d == BUSY);
    result_valid_d = (state_d == DONE);
  end

  // Status flags registered alongside the state so outputs come from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      start_ready_q  <= start_ready_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Shift-and-add datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {WIDTH'(0), bus.a};
      mplier_q <= bus.b;
      count_q  <= '0;
    end else if (step) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_step;
      mplier_q <= mplier_step;
      count_q  <= count_step;
    end
  end

  // Product only changes when a new result is completed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= '0;
    end else if (finish) begin
      product_q <= acc_step;
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.product      = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=4), both build variants.
module tb_shift_add_multiplier;

  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         rr_delay;
    logic [7:0] prod;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [3:0] b);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    int l = 1;
    for (int i = 0; i < 4; i++) if (b[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.start_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("start_ready_timeout", 32'(bus.start_ready), 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.result_valid && lat < 40);
    if (!bus.result_valid) check("result_valid_timeout", 32'(bus.result_valid), 32'd1);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(name, 32'(bus.product), 32'(e));
    end
  endtask

  // Full transaction: accept, latency, product, optional backpressure, release.
  task automatic run_mul(input logic [3:0] a, input logic [3:0] b, input int rr_delay, input string name);
    int lat;
    logic [7:0] held;
    wait_ready();
    bus.a = a;
    bus.b = b;
    bus.start_valid = 1'b1;
    bus.result_ready = (rr_delay == 0);
    sb.push_back(8'(a) * 8'(b));
    tick();
    bus.start_valid = 1'b0;
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    check({name, "_sr_low"}, 32'(bus.start_ready), 32'd0);
    wait_valid(lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat(b)));
    held = bus.product;
    pop_check({name, "_product"});
    for (int d = 0; d < rr_delay; d++) begin
      tick();
      check({name, "_bp_product"}, 32'(bus.product), 32'(held));
      check({name, "_bp_valid"}, 32'(bus.result_valid), 32'd1);
      check({name, "_bp_sr"}, 32'(bus.start_ready), 32'd0);
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(bus.result_valid), 32'd0);
    check({name, "_sr_back"}, 32'(bus.start_ready), 32'd1);
    check({name, "_product_kept"}, 32'(bus.product), 32'(held));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int lat;
    tbl[0] = '{a: 4'd13, b: 4'd11,     rr_delay: 0, prod: 8'd143};
    tbl[1] = '{a: 4'd15, b: 4'd15,     rr_delay: 0, prod: 8'd225};
    tbl[2] = '{a: 4'd0,  b: 4'd9,      rr_delay: 1, prod: 8'd0};
    tbl[3] = '{a: 4'd9,  b: 4'd1,      rr_delay: 0, prod: 8'd9};
    tbl[4] = '{a: 4'd9,  b: 4'd0,      rr_delay: 2, prod: 8'd0};
    tbl[5] = '{a: 4'd9,  b: 4'b1000,   rr_delay: 0, prod: 8'd72};
    tbl[6] = '{a: 4'd1,  b: 4'd2,      rr_delay: 3, prod: 8'd2};

    rst_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.result_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;

    // Reset held with random traffic: nothing may move.
    for (int i = 0; i < 6; i++) begin
      bus.start_valid = 1'($urandom);
      bus.result_ready = 1'($urandom);
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      tick();
      check("rst_product", 32'(bus.product), 32'd0);
      check("rst_valid", 32'(bus.result_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_sr", 32'(bus.start_ready), 32'd1);
    end
    bus.start_valid = 1'b0;
    bus.result_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_after_rst", 32'(bus.busy), 32'd0);

    // Directed vectors; the table's product column is cross-checked against the model.
    for (int i = 0; i < 7; i++) begin
      check($sformatf("tbl%0d_model", i), 32'(8'(tbl[i].a) * 8'(tbl[i].b)), 32'(tbl[i].prod));
      run_mul(tbl[i].a, tbl[i].b, tbl[i].rr_delay, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_const", i), 32'(bus.product), 32'(tbl[i].prod));
    end

    // Backpressure with start_valid held high and fresh operands waiting.
    wait_ready();
    bus.a = 4'd7;
    bus.b = 4'd6;
    bus.start_valid = 1'b1;
    bus.result_ready = 1'b0;
    sb.push_back(8'd42);
    tick();
    bus.a = 4'd2;
    bus.b = 4'd3;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'(exp_lat(4'd6)));
    pop_check("bp_product");
    for (int d = 0; d < 5; d++) begin
      tick();
      check("bp_hold_product", 32'(bus.product), 32'd42);
      check("bp_hold_valid", 32'(bus.result_valid), 32'd1);
      check("bp_hold_sr", 32'(bus.start_ready), 32'd0);
      check("bp_hold_busy", 32'(bus.busy), 32'd0);
    end
    bus.result_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus.result_valid), 32'd0);
    check("bp_release_sr", 32'(bus.start_ready), 32'd1);
    sb.push_back(8'd6);
    tick();
    bus.start_valid = 1'b0;
    check("bp_next_busy", 32'(bus.busy), 32'd1);
    wait_valid(lat);
    check("bp_next_latency", 32'(lat), 32'(exp_lat(4'd3)));
    pop_check("bp_next_product");
    tick();
    bus.result_ready = 1'b0;
    check("bp_next_done", 32'(bus.result_valid), 32'd0);

    // Reset in the second BUSY cycle of 9*9, with a nonzero product held from before.
    run_mul(4'd4, 4'd5, 0, "pre_rst");
    bus.a = 4'd9;
    bus.b = 4'd9;
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_product", 32'(bus.product), 32'd0);
    check("midrst_valid", 32'(bus.result_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_sr", 32'(bus.start_ready), 32'd1);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_result", 32'(bus.result_valid), 32'd0);
    end
    run_mul(4'd3, 4'd5, 0, "post_rst");
    check("post_rst_15", 32'(bus.product), 32'd15);

    // Exhaustive sweep against the behavioural a*b model.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        run_mul(4'(ai), 4'(bi), 0, $sformatf("sweep_%0d_%0d", ai, bi));
      end
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
